// File: rtl/stream_mux_arb_pkg.sv
// Shared definitions for the stream_mux_arb family: arbitration mode codes
// and a select-width helper reused by the fixed and wide mux variants.
package stream_mux_arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Bits needed to encode n channel indices; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Combinational arbiter: one-hot grant plus encoded index, either fixed
// priority (lowest index) or round-robin scanning upward from ptr.
module rr_arbiter
  import stream_mux_arb_pkg::*;
#(
  parameter  int NCH      = 4,
  parameter  int ARB_MODE = ARB_RR,
  localparam int SEL_W    = clog2_min1(NCH)
) (
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  output logic [NCH-1:0]   grant,
  output logic [SEL_W-1:0] idx
);

  int   start;
  int   cand;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    // Fixed priority is round-robin with the scan anchored at channel 0.
    start = (ARB_MODE == ARB_RR) ? int'(ptr) : 0;
    for (int k = 0; k < NCH; k++) begin
      cand = (start + k) % NCH;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = SEL_W'(cand);
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel arbitrated stream mux with a single registered output stage and
// valid/ready backpressure; accepts a new word in the same cycle one drains.
module stream_mux_arb
  import stream_mux_arb_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int NCH      = 4,
  parameter  int ARB_MODE = ARB_RR,
  localparam int SEL_W    = clog2_min1(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel
);

  logic [WIDTH-1:0] ch_data [NCH];

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [NCH-1:0]   grant;
  logic [SEL_W-1:0] grant_idx;
  logic             load;

  rr_arbiter #(
    .NCH      (NCH),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .req   (in_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (grant_idx)
  );

  // Output slot is free when empty or being drained this cycle.
  assign load     = rst_n & (~out_valid_q | out_ready);
  assign in_ready = grant & {NCH{load}};

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (|grant) begin
        out_valid_d = 1'b1;
        out_data_d  = ch_data[grant_idx];
        out_sel_d   = grant_idx;
        if (ARB_MODE == ARB_RR) begin
          ptr_d = (int'(grant_idx) == NCH - 1) ? '0 : grant_idx + 1'b1;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb: a round-robin and a fixed-priority
// instance share stimulus; each task checks its own scenario inline.
module tb_stream_mux_arb;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;

  logic             clk;
  logic             rst_n;
  logic [NCH-1:0]   in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic             out_ready;

  logic [NCH-1:0]   rr_in_ready, fx_in_ready;
  logic             rr_out_valid, fx_out_valid;
  logic [WIDTH-1:0] rr_out_data, fx_out_data;
  logic [1:0]       rr_out_sel, fx_out_sel;

  int vectors;
  int miscompares;

  stream_mux_arb #(.WIDTH(WIDTH), .NCH(NCH), .ARB_MODE(1)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (rr_in_ready),
    .in_data   (in_data),
    .out_valid (rr_out_valid),
    .out_ready (out_ready),
    .out_data  (rr_out_data),
    .out_sel   (rr_out_sel)
  );

  stream_mux_arb #(.WIDTH(WIDTH), .NCH(NCH), .ARB_MODE(0)) u_fx (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (fx_in_ready),
    .in_data   (in_data),
    .out_valid (fx_out_valid),
    .out_ready (out_ready),
    .out_data  (fx_out_data),
    .out_sel   (fx_out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (rr_in_ready !== 4'b0000) begin
        $display("FAIL reset_in_ready cyc%0d: got %b expected 0000", c, rr_in_ready);
        miscompares++;
      end
      vectors++;
      if (rr_out_valid !== 1'b0) begin
        $display("FAIL reset_out_valid cyc%0d: got %b expected 0", c, rr_out_valid);
        miscompares++;
      end
      vectors++;
      if (rr_out_data !== 8'h00 || rr_out_sel !== 2'd0) begin
        $display("FAIL reset_out_data_sel cyc%0d: got %h/%0d expected 00/0", c, rr_out_data, rr_out_sel);
        miscompares++;
      end
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (rr_in_ready !== 4'b0001) begin
      $display("FAIL reset_release_grant: got %b expected 0001", rr_in_ready);
      miscompares++;
    end
    tick();
    $display("txn reset_release sel=%0d data=%h", rr_out_sel, rr_out_data);
    vectors++;
    if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd0 || rr_out_data !== 8'hA0) begin
      $display("FAIL reset_first_word: got v=%b sel=%0d data=%h expected v=1 sel=0 data=a0",
               rr_out_valid, rr_out_sel, rr_out_data);
      miscompares++;
    end
  endtask

  task automatic test_round_robin();
    int exp_sel [5] = '{0, 1, 2, 3, 0};
    do_reset();
    in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if (rr_in_ready !== (4'b0001 << exp_sel[k])) begin
        $display("FAIL rr_in_ready step%0d: got %b expected %b", k, rr_in_ready, 4'b0001 << exp_sel[k]);
        miscompares++;
      end
      tick();
      $display("txn rr step%0d sel=%0d data=%h", k, rr_out_sel, rr_out_data);
      vectors++;
      if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'(exp_sel[k]) ||
          rr_out_data !== 8'(8'hA0 + exp_sel[k])) begin
        $display("FAIL rr_out step%0d: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h",
                 k, rr_out_valid, rr_out_sel, rr_out_data, exp_sel[k], 8'(8'hA0 + exp_sel[k]));
        miscompares++;
      end
    end
  endtask

  task automatic test_sparse();
    int exp_sel [3] = '{1, 3, 1};
    do_reset();
    in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (rr_in_ready !== (4'b0001 << exp_sel[k])) begin
        $display("FAIL sparse_in_ready step%0d: got %b expected %b", k, rr_in_ready, 4'b0001 << exp_sel[k]);
        miscompares++;
      end
      tick();
      $display("txn sparse step%0d sel=%0d data=%h", k, rr_out_sel, rr_out_data);
      vectors++;
      if (rr_out_sel !== 2'(exp_sel[k]) || rr_out_data !== 8'(8'hA0 + exp_sel[k])) begin
        $display("FAIL sparse_out step%0d: got sel=%0d data=%h expected sel=%0d data=%h",
                 k, rr_out_sel, rr_out_data, exp_sel[k], 8'(8'hA0 + exp_sel[k]));
        miscompares++;
      end
    end
  endtask

  task automatic test_idle_hold();
    do_reset();
    in_valid = 4'b0010;
    tick();
    in_valid = 4'b0000;
    tick();
    $display("txn idle sel=%0d data=%h valid=%b", rr_out_sel, rr_out_data, rr_out_valid);
    vectors++;
    if (rr_out_valid !== 1'b0 || rr_out_sel !== 2'd1 || rr_out_data !== 8'hA1) begin
      $display("FAIL idle_hold: got v=%b sel=%0d data=%h expected v=0 sel=1 data=a1",
               rr_out_valid, rr_out_sel, rr_out_data);
      miscompares++;
    end
    in_valid = 4'b1111;
    #1;
    vectors++;
    if (rr_in_ready !== 4'b0100) begin
      $display("FAIL idle_ptr_hold: got %b expected 0100", rr_in_ready);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 4'b1111;
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (rr_in_ready !== 4'b0000) begin
        $display("FAIL stall_in_ready cyc%0d: got %b expected 0000", c, rr_in_ready);
        miscompares++;
      end
      tick();
      $display("txn stall cyc%0d sel=%0d data=%h", c, rr_out_sel, rr_out_data);
      vectors++;
      if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd2 || rr_out_data !== 8'hA2) begin
        $display("FAIL stall_hold cyc%0d: got v=%b sel=%0d data=%h expected v=1 sel=2 data=a2",
                 c, rr_out_valid, rr_out_sel, rr_out_data);
        miscompares++;
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (rr_in_ready !== 4'b1000) begin
      $display("FAIL release_in_ready: got %b expected 1000", rr_in_ready);
      miscompares++;
    end
    tick();
    $display("txn release sel=%0d data=%h", rr_out_sel, rr_out_data);
    vectors++;
    if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd3 || rr_out_data !== 8'hA3) begin
      $display("FAIL release_no_bubble: got v=%b sel=%0d data=%h expected v=1 sel=3 data=a3",
               rr_out_valid, rr_out_sel, rr_out_data);
      miscompares++;
    end
  endtask

  task automatic test_fixed_priority();
    int exp_sel [3] = '{2, 2, 0};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      in_valid = (k < 2) ? 4'b1100 : 4'b1101;
      #1;
      vectors++;
      if (fx_in_ready !== (4'b0001 << exp_sel[k])) begin
        $display("FAIL fixed_in_ready step%0d: got %b expected %b", k, fx_in_ready, 4'b0001 << exp_sel[k]);
        miscompares++;
      end
      tick();
      $display("txn fixed step%0d sel=%0d data=%h", k, fx_out_sel, fx_out_data);
      vectors++;
      if (fx_out_valid !== 1'b1 || fx_out_sel !== 2'(exp_sel[k]) ||
          fx_out_data !== 8'(8'hA0 + exp_sel[k])) begin
        $display("FAIL fixed_out step%0d: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h",
                 k, fx_out_valid, fx_out_sel, fx_out_data, exp_sel[k], 8'(8'hA0 + exp_sel[k]));
        miscompares++;
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    in_valid = 4'b1111;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rr_in_ready !== 4'b0000) begin
      $display("FAIL midrst_in_ready: got %b expected 0000", rr_in_ready);
      miscompares++;
    end
    tick();
    vectors++;
    if (rr_out_valid !== 1'b0 || fx_out_valid !== 1'b0 || rr_out_data !== 8'h00) begin
      $display("FAIL midrst_out: got rr_v=%b fx_v=%b data=%h expected 0/0/00",
               rr_out_valid, fx_out_valid, rr_out_data);
      miscompares++;
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (rr_in_ready !== 4'b0001) begin
      $display("FAIL midrst_ptr: got %b expected 0001", rr_in_ready);
      miscompares++;
    end
    tick();
    $display("txn midrst sel=%0d data=%h", rr_out_sel, rr_out_data);
    vectors++;
    if (rr_out_sel !== 2'd0 || rr_out_data !== 8'hA0) begin
      $display("FAIL midrst_first: got sel=%0d data=%h expected sel=0 data=a0", rr_out_sel, rr_out_data);
      miscompares++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = '0;
    out_ready   = 1'b1;
    in_data     = 32'hA3A2A1A0;
    test_reset();
    test_round_robin();
    test_sparse();
    test_idle_hold();
    test_back_to_back();
    test_fixed_priority();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
